// File: rtl/cla_sub_pkg.sv
// Shared widths and types for the pipelined 64-bit CLA subtractor.
// Optional flag outputs are enabled with the CLA_SUB_FLAGS_EN macro (see top).
package cla_sub_pkg;
    localparam int W     = 64;
    localparam int SPLIT = 32;
    localparam int GRP   = 4;
    localparam int SGRP  = 16;

    typedef logic [W-1:0] word_t;
endpackage

// File: rtl/cla_group4.sv
// 4-wide carry-lookahead cell: used on bits, on 4-bit groups and on 16-bit supergroups.
// Each output is a separate assign so carry and group terms stay independent nets.
module cla_group4
    import cla_sub_pkg::*;
(
    input  logic [GRP-1:0] p,
    input  logic [GRP-1:0] g,
    input  logic           cin,
    output logic [GRP-1:0] c,
    output logic           gg,
    output logic           gp,
    output logic [GRP-1:0] sum
);
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign gp = &p;

    assign sum = p ^ c;
endmodule

// File: rtl/cla_sub_64bit_pipe.sv
// Two-stage pipelined 64-bit CLA subtractor (diff = a - b - bin) with valid/ready handshakes.
// Define CLA_SUB_FLAGS_EN to add registered zero/neg/ovf flag outputs.
module cla_sub_64bit_pipe
    import cla_sub_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef CLA_SUB_FLAGS_EN
    ,
    output logic         zero,
    output logic         neg,
    output logic         ovf
`endif
);
    localparam int NG  = SPLIT / GRP;
    localparam int NSG = SPLIT / SGRP;
    localparam int GPS = SGRP / GRP;

    logic                   vld_p1, vld_p2;
    logic [SPLIT-1:0]       diff_lo_p1;
    logic                   c32_p1;
    logic [W-SPLIT-1:0]     a_hi_p1, nb_hi_p1;
    word_t                  diff_p2;
    logic                   bout_p2;

    // Each half of the word is a 32-bit lookahead adder on (a, ~b); half 0 is
    // fed from the inputs, half 1 from the stage-1 register.
    logic [1:0][SPLIT-1:0]  hp, hg, hsum;
    logic [1:0]             hcin, hcout;

    assign hp[0]   = a[SPLIT-1:0] ^ ~b[SPLIT-1:0];
    assign hg[0]   = a[SPLIT-1:0] & ~b[SPLIT-1:0];
    assign hcin[0] = ~bin;
    assign hp[1]   = a_hi_p1 ^ nb_hi_p1;
    assign hg[1]   = a_hi_p1 & nb_hi_p1;
    assign hcin[1] = c32_p1;

    for (genvar h = 0; h < 2; h++) begin : g_half
        logic [NG-1:0]            grp_g, grp_p, grp_c;
        logic [SPLIT-1:0]         bit_c;
        logic [NSG-1:0]           sg_g, sg_p;
        logic [NSG-1:0][GRP-1:0]  sg_sum;
        logic [GRP-1:0]           top_c, top_sum;
        logic                     top_gg, top_gp;
        logic                     unused_half;

        for (genvar k = 0; k < NG; k++) begin : g_bit
            cla_group4 u_bit (
                .p   (hp[h][k*GRP +: GRP]),
                .g   (hg[h][k*GRP +: GRP]),
                .cin (grp_c[k]),
                .c   (bit_c[k*GRP +: GRP]),
                .gg  (grp_g[k]),
                .gp  (grp_p[k]),
                .sum (hsum[h][k*GRP +: GRP])
            );
        end

        for (genvar s = 0; s < NSG; s++) begin : g_sg
            cla_group4 u_sg (
                .p   (grp_p[s*GPS +: GPS]),
                .g   (grp_g[s*GPS +: GPS]),
                .cin (top_c[s]),
                .c   (grp_c[s*GPS +: GPS]),
                .gg  (sg_g[s]),
                .gp  (sg_p[s]),
                .sum (sg_sum[s])
            );
        end

        // Only NSG supergroups exist; the unused upper lanes are tied off so
        // top_c[NSG] is the carry out of the whole half.
        cla_group4 u_top (
            .p   ({{(GRP-NSG){1'b0}}, sg_p}),
            .g   ({{(GRP-NSG){1'b0}}, sg_g}),
            .cin (hcin[h]),
            .c   (top_c),
            .gg  (top_gg),
            .gp  (top_gp),
            .sum (top_sum)
        );

        assign hcout[h]    = top_c[NSG];
        assign unused_half = ^{bit_c, sg_sum, top_c[GRP-1], top_sum, top_gg, top_gp};
    end

    logic adv_p1, adv_p2;

    assign in_ready = !vld_p1 || !vld_p2 || out_ready;
    assign adv_p1   = in_valid && in_ready;
    assign adv_p2   = vld_p1 && (!vld_p2 || out_ready);

`ifdef CLA_SUB_FLAGS_EN
    logic sa_p1, sb_p1;
    logic zero_p2, neg_p2, ovf_p2;
    word_t diff_next;
    assign diff_next = {hsum[1], diff_lo_p1};
`endif

    // Stage 1: low half resolved, carry into bit SPLIT captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            diff_lo_p1 <= '0;
            c32_p1     <= 1'b0;
            a_hi_p1    <= '0;
            nb_hi_p1   <= '0;
`ifdef CLA_SUB_FLAGS_EN
            sa_p1      <= 1'b0;
            sb_p1      <= 1'b0;
`endif
        end else begin
            if (adv_p1) begin
                vld_p1     <= 1'b1;
                diff_lo_p1 <= hsum[0];
                c32_p1     <= hcout[0];
                a_hi_p1    <= a[W-1:SPLIT];
                nb_hi_p1   <= ~b[W-1:SPLIT];
`ifdef CLA_SUB_FLAGS_EN
                sa_p1      <= a[W-1];
                sb_p1      <= b[W-1];
`endif
            end else if (adv_p2) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Stage 2: high half resolved, borrow-out is the inverted final carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            diff_p2 <= '0;
            bout_p2 <= 1'b0;
`ifdef CLA_SUB_FLAGS_EN
            zero_p2 <= 1'b0;
            neg_p2  <= 1'b0;
            ovf_p2  <= 1'b0;
`endif
        end else begin
            if (adv_p2) begin
                vld_p2  <= 1'b1;
                diff_p2 <= {hsum[1], diff_lo_p1};
                bout_p2 <= ~hcout[1];
`ifdef CLA_SUB_FLAGS_EN
                zero_p2 <= (diff_next == '0);
                neg_p2  <= diff_next[W-1];
                ovf_p2  <= (sa_p1 ^ sb_p1) & (sa_p1 ^ diff_next[W-1]);
`endif
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p2;
    assign diff      = diff_p2;
    assign bout      = bout_p2;
`ifdef CLA_SUB_FLAGS_EN
    assign zero      = zero_p2;
    assign neg       = neg_p2;
    assign ovf       = ovf_p2;
`endif
endmodule

// File: tb/tb_cla_sub_64bit_pipe.sv
// Self-checking bench for cla_sub_64bit_pipe: directed vector table, backpressure,
// random streaming against a 65-bit reference, and asynchronous reset mid-flight.
module tb_cla_sub_64bit_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] a, b;
    logic        bin;
    logic        out_valid, out_ready;
    logic [63:0] diff;
    logic        bout;
`ifdef CLA_SUB_FLAGS_EN
    logic        zero, neg, ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cla_sub_64bit_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef CLA_SUB_FLAGS_EN
        ,
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] diff;
        logic        bout;
        logic        zero;
        logic        neg;
        logic        ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [64:0] ref_sub(input logic [63:0] x, input logic [63:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - {64'd0, bi};
    endfunction

    task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic bi);
        a = x;
        b = y;
        bin = bi;
        in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_d[4];
        logic [64:0] r;
        logic [63:0] ra, rb;
        logic        rbin;
        logic [64:0] q[$];
        int          sent, got, cyc;

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{64'd10, 64'd3, 1'b1, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{64'd3, 64'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_diff", diff, 64'd0);
        check("reset_bout", {63'd0, bout}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed table: one beat at a time, latency checked on each.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("vec%0d_lat1_valid", i), {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
            check($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
            check($sformatf("vec%0d_bout", i), {63'd0, bout}, {63'd0, vecs[i].bout});
`ifdef CLA_SUB_FLAGS_EN
            check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].zero});
            check($sformatf("vec%0d_neg", i), {63'd0, neg}, {63'd0, vecs[i].neg});
            check($sformatf("vec%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].ovf});
`endif
        end
        @(negedge clk);
        check("idle_out_valid", {63'd0, out_valid}, 64'd0);

        // Backpressure: four beats offered with the consumer stalled.
        for (int i = 0; i < 4; i++) begin
            r = ref_sub(64'd1000 * (i + 1), 64'(i + 1), i[0]);
            exp_d[i] = r[63:0];
        end
        out_ready = 1'b0;
        drive(64'd1000, 64'd1, 1'b0);
        @(negedge clk);
        drive(64'd2000, 64'd2, 1'b1);
        @(negedge clk);
        drive(64'd3000, 64'd3, 1'b0);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        check("bp_diff_first", diff, exp_d[0]);
        @(negedge clk);
        check("bp_in_ready_hold", {63'd0, in_ready}, 64'd0);
        check("bp_diff_hold", diff, exp_d[0]);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_drain1", diff, exp_d[1]);
        drive(64'd4000, 64'd4, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_drain2", diff, exp_d[2]);
        @(negedge clk);
        check("bp_drain3_valid", {63'd0, out_valid}, 64'd1);
        check("bp_drain3", diff, exp_d[3]);
        @(negedge clk);
        check("bp_empty", {63'd0, out_valid}, 64'd0);

        // Back-to-back random stream, one beat per cycle.
        sent = 0;
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 200) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("stream_unexpected_beat", {63'd0, out_valid}, 64'd0);
                end else begin
                    r = q.pop_front();
                    check($sformatf("stream%0d_diff", got), diff, r[63:0]);
                    check($sformatf("stream%0d_bout", got), {63'd0, bout}, {63'd0, r[64]});
                end
                got++;
            end
            if (sent < 100) begin
                ra = {$urandom, $urandom};
                rb = (sent % 4 == 0) ? ra : {$urandom, $urandom};
                rbin = 1'($urandom_range(0, 1));
                drive(ra, rb, rbin);
                q.push_back(ref_sub(ra, rb, rbin));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        check("stream_count", 64'(got), 64'd100);
        check("stream_cycles", {63'd0, (cyc <= 103)}, 64'd1);

        // Asynchronous reset with both stages full.
        out_ready = 1'b0;
        drive(64'd77, 64'd7, 1'b0);
        @(negedge clk);
        drive(64'd88, 64'd8, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_full", {63'd0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", {63'd0, out_valid}, 64'd0);
        check("rst_async_diff", diff, 64'd0);
        check("rst_async_bout", {63'd0, bout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_no_stale%0d", i), {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cla_sub_64bit_pipe.md
Name: cla_sub_64bit_pipe

Overview:
Two-stage pipelined 64-bit carry-lookahead subtractor computing diff = a - b - bin, with borrow-out.
- Complements the existing combinational CLA adder: the datapath uses inverted-operand addition.
- Uses valid/ready handshakes on input and output, so it can sit between streaming producer/consumer stages in the ALU path.
- Stage 1 resolves the low 32 bits and the borrow into bit 32. Stage 2 resolves the high 32 bits and bout.

Parameters:
- W, 64, operand width; fixed at 64, must be a multiple of 32.
- SPLIT, 32, bit index where the pipeline register cuts the carry chain.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  64  minuend
- b  in  64  subtrahend
- bin  in  1  borrow-in
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- diff  out  64  a - b - bin, modulo 2^64
- bout  out  1  borrow-out; 1 when unsigned a < b + bin

Behaviour:
- Arithmetic: diff = a + ~b + ~bin; carry c64 from the lookahead network; bout = ~c64.
- Lookahead structure: per-bit p = a ^ ~b, g = a & ~b; 4-bit groups; 16-bit supergroups.
- Stage 1 register holds: s1_valid, low diff[31:0], carry c32, a[63:32], ~b[63:32].
- Stage 2 register holds: s2_valid, diff[63:0], bout. diff, bout and out_valid are driven directly from stage-2 registers.
- Latency: exactly 2 cycles from in_valid & in_ready to out_valid, when not stalled.
- Throughput: 1 beat per cycle when out_ready stays high.
- Stage 2 loads when s1_valid & (!s2_valid | out_ready).
- Stage 1 loads when in_valid & in_ready.
- in_ready = !s1_valid | !s2_valid | out_ready. No combinational path from in_valid to out_valid.
- Stall: with out_ready=0 and both stages full, in_ready=0. Registers and outputs hold, and diff/bout stay stable while out_valid=1.
- Simultaneous accept and consume: handled in the same cycle with no bubble.
- Reset (async, any time including mid-operation):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - diff=0, bout=0, stage data registers=0.
  - In-flight beats are discarded.
  - in_ready=1 from the first cycle after rst_n rises.
- Data registers load only on their stage's advance condition, never on an invalid beat.
- Wrap-around: 0 - 1 gives diff = all ones, bout = 1. Borrow propagates across the SPLIT boundary through c32.

Optional Feature:
CLA_SUB_FLAGS_EN
- Defined: adds output ports zero (1, diff==0), neg (1, diff[63]) and ovf (1, signed overflow = (a[63]^b[63]) & (a[63]^diff[63])).
  - All three are registered in stage 2 alongside diff and reset to 0.
  - Stage 1 additionally carries a[63] and b[63] to support ovf.
- Undefined: the flag ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package cla_sub_pkg: W=64, SPLIT=32, group size 4, supergroup size 16, and typedef word_t (logic [63:0]).
- One natural sub-module: cla_group4. It takes 4-bit p/g and carry-in, and produces group G/P, internal carries and 4-bit sum. It is instantiated 16 times for bits and reused for the supergroup levels.

Test Plan:
1. a=5, b=3, bin=0 -> after 2 cycles diff=2, bout=0.
2. a=0, b=1, bin=0 -> diff=0xFFFF_FFFF_FFFF_FFFF, bout=1; with flags enabled, neg=1, zero=0, ovf=0.
3. Split boundary: a=0x0000_0001_0000_0000, b=1 -> diff=0x0000_0000_FFFF_FFFF, bout=0. Also a=b=0x1234_5678_9ABC_DEF0 with bin=1 -> diff=all ones, bout=1.
4. Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepts and diff holds the first result. Raising out_ready drains results in order with no loss or duplication.
5. Back-to-back streaming with out_ready=1: 100 random operand pairs give one result per cycle, each matching a reference model (including bout).
6. Reset mid-flight: assert rst_n=0 with both stages full -> out_valid=0 and diff=0 immediately (async). After release, in_ready=1 and no stale beat ever appears.
